// File: rtl/buck_state_uart_tx.sv
// buck_state_uart_tx: samples the four buck-converter solver state words every
// DECIM enabled cycles and sends each snapshot to the host as a 10-byte 8N1
// UART frame: A5, v_1i hi/lo, v_2i hi/lo, v_1d hi/lo, v_2d hi/lo, checksum.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   en_i         decimation counter enable (0 holds the counter at 0)
//   v_1i_i..v_2d_i  solver state words (two's complement)
//   tx_o         UART serial output, idle high
//   busy_o       high from the cycle after capture until the final stop bit ends
//   drop_o       one-cycle pulse, registered, after a request that arrived while busy
//   frame_cnt_o  count of fully transmitted frames, wraps at 16 bits
module buck_state_uart_tx #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLK_DIV = 434,
  parameter int unsigned DECIM   = 50000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] v_1i_i,
  input  logic [DATA_W-1:0] v_2i_i,
  input  logic [DATA_W-1:0] v_1d_i,
  input  logic [DATA_W-1:0] v_2d_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              drop_o,
  output logic [15:0]       frame_cnt_o
);

  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DCNT_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned LAST_BYTE = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state;
  logic [DCNT_W-1:0] dcnt;
  logic [DIV_W-1:0]  div;
  logic [2:0]        bit_idx;
  logic [3:0]        byte_idx;
  logic [15:0]       sh_1i, sh_2i, sh_1d, sh_2d;
  logic [7:0]        csum;
  logic [7:0]        cur_byte;
  logic              tick;
  logic              div_end;

  assign tick    = en_i && (dcnt == DCNT_W'(DECIM - 1));
  assign div_end = (div == DIV_W'(CLK_DIV - 1));

  // Decimation counter: free-runs while enabled, cleared when disabled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dcnt <= '0;
    end else if (!en_i || tick) begin
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + DCNT_W'(1);
    end
  end

  // Byte currently on the wire, selected from the shadow snapshot.
  always_comb begin
    cur_byte = 8'hA5;
    case (byte_idx)
      4'd1:    cur_byte = sh_1i[15:8];
      4'd2:    cur_byte = sh_1i[7:0];
      4'd3:    cur_byte = sh_2i[15:8];
      4'd4:    cur_byte = sh_2i[7:0];
      4'd5:    cur_byte = sh_1d[15:8];
      4'd6:    cur_byte = sh_1d[7:0];
      4'd7:    cur_byte = sh_2d[15:8];
      4'd8:    cur_byte = sh_2d[7:0];
      4'd9:    cur_byte = csum;
      default: cur_byte = 8'hA5;
    endcase
  end

  // Frame FSM; tx_o is loaded one cycle ahead so every bit is registered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      tx_o        <= 1'b1;
      busy_o      <= 1'b0;
      drop_o      <= 1'b0;
      frame_cnt_o <= '0;
      div         <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      sh_1i       <= '0;
      sh_2i       <= '0;
      sh_1d       <= '0;
      sh_2d       <= '0;
      csum        <= '0;
    end else begin
      drop_o <= tick && (state != IDLE);
      case (state)
        IDLE: begin
          tx_o <= 1'b1;
          if (tick) begin
            sh_1i    <= v_1i_i[15:0];
            sh_2i    <= v_2i_i[15:0];
            sh_1d    <= v_1d_i[15:0];
            sh_2d    <= v_2d_i[15:0];
            csum     <= v_1i_i[15:8] + v_1i_i[7:0] + v_2i_i[15:8] + v_2i_i[7:0]
                      + v_1d_i[15:8] + v_1d_i[7:0] + v_2d_i[15:8] + v_2d_i[7:0];
            byte_idx <= '0;
            div      <= '0;
            busy_o   <= 1'b1;
            tx_o     <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (div_end) begin
            div     <= '0;
            bit_idx <= '0;
            tx_o    <= cur_byte[0];
            state   <= DATA;
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        DATA: begin
          if (div_end) begin
            div <= '0;
            if (bit_idx == 3'd7) begin
              tx_o  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_o    <= cur_byte[3'(bit_idx + 3'd1)];
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        STOP: begin
          if (div_end) begin
            div <= '0;
            if (byte_idx != 4'(LAST_BYTE)) begin
              byte_idx <= byte_idx + 4'd1;
              tx_o     <= 1'b0;
              state    <= START;
            end else begin
              busy_o      <= 1'b0;
              frame_cnt_o <= frame_cnt_o + 16'd1;
              state       <= IDLE;
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buck_state_uart_tx.sv
// Bench for buck_state_uart_tx: two instances (DECIM=500 and DECIM=300, CLK_DIV=4)
// checked every cycle against a frame-position model, plus literal frame checks.
module tb_buck_state_uart_tx;

  localparam int CD = 4;
  localparam int DA = 500;
  localparam int DB = 300;
  localparam int FRAME = 100 * CD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0, en_a = 1'b0, en_b = 1'b0;
  logic [15:0] a_1i = '0, a_2i = '0, a_1d = '0, a_2d = '0;
  logic [15:0] b_1i = 16'h1111, b_2i = 16'h2222, b_1d = 16'h3333, b_2d = 16'h4444;
  logic tx_a, busy_a, drop_a, tx_b, busy_b, drop_b;
  logic [15:0] fc_a, fc_b;

  buck_state_uart_tx #(.DATA_W(16), .CLK_DIV(CD), .DECIM(DA)) dut_a (
    .clk_i(clk), .rst_n_i(rst_a), .en_i(en_a),
    .v_1i_i(a_1i), .v_2i_i(a_2i), .v_1d_i(a_1d), .v_2d_i(a_2d),
    .tx_o(tx_a), .busy_o(busy_a), .drop_o(drop_a), .frame_cnt_o(fc_a));

  buck_state_uart_tx #(.DATA_W(16), .CLK_DIV(CD), .DECIM(DB)) dut_b (
    .clk_i(clk), .rst_n_i(rst_b), .en_i(en_b),
    .v_1i_i(b_1i), .v_2i_i(b_2i), .v_1d_i(b_1d), .v_2d_i(b_2d),
    .tx_o(tx_b), .busy_o(busy_b), .drop_o(drop_b), .frame_cnt_o(fc_b));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else passed++;
  endtask

  // Model: pos = cycles since capture (0 = idle); a frame is 100 bits of CD cycles.
  int          pos[2];
  int          run[2];
  logic [15:0] frames[2];
  logic        drop_m[2];
  logic [99:0] fb[2];

  task automatic m_reset(input int i);
    pos[i] = 0; run[i] = 0; frames[i] = '0; drop_m[i] = 1'b0; fb[i] = '1;
  endtask

  task automatic m_step(input int i, input logic en, input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] w2, input logic [15:0] w3, input int decim);
    logic        tick;
    logic [7:0]  by [10];
    int          s;
    tick = 1'b0;
    if (en) begin
      run[i]++;
      tick = (run[i] % decim) == 0;
    end else begin
      run[i] = 0;
    end
    drop_m[i] = 1'b0;
    if (pos[i] == 0) begin
      if (tick) begin
        by[0] = 8'hA5;
        by[1] = w0[15:8]; by[2] = w0[7:0]; by[3] = w1[15:8]; by[4] = w1[7:0];
        by[5] = w2[15:8]; by[6] = w2[7:0]; by[7] = w3[15:8]; by[8] = w3[7:0];
        s = 0;
        for (int k = 1; k <= 8; k++) s += int'(by[k]);
        by[9] = 8'(s % 256);
        for (int b = 0; b < 10; b++) begin
          fb[i][b*10] = 1'b0;
          for (int k = 0; k < 8; k++) fb[i][b*10+1+k] = by[b][k];
          fb[i][b*10+9] = 1'b1;
        end
        pos[i] = 1;
      end
    end else begin
      drop_m[i] = tick;
      if (pos[i] == FRAME) begin
        pos[i] = 0;
        frames[i] = frames[i] + 16'd1;
      end else begin
        pos[i]++;
      end
    end
  endtask

  function automatic logic exp_tx(input int i);
    return (pos[i] == 0) ? 1'b1 : fb[i][(pos[i] - 1) / CD];
  endfunction

  always @(posedge clk or negedge rst_a)
    if (!rst_a) m_reset(0);
    else m_step(0, en_a, a_1i, a_2i, a_1d, a_2d, DA);

  always @(posedge clk or negedge rst_b)
    if (!rst_b) m_reset(1);
    else m_step(1, en_b, b_1i, b_2i, b_1d, b_2d, DB);

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("a_tx",   32'(tx_a),   32'(exp_tx(0)));
    chk("a_busy", 32'(busy_a), 32'(pos[0] != 0));
    chk("a_drop", 32'(drop_a), 32'(drop_m[0]));
    chk("a_cnt",  32'(fc_a),   32'(frames[0]));
    chk("b_tx",   32'(tx_b),   32'(exp_tx(1)));
    chk("b_busy", 32'(busy_b), 32'(pos[1] != 0));
    chk("b_drop", 32'(drop_b), 32'(drop_m[1]));
    chk("b_cnt",  32'(fc_b),   32'(frames[1]));
  end

  logic [7:0] f1 [10] = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hBD};
  logic [7:0] f2 [10] = '{8'hA5, 8'h80, 8'h01, 8'h7F, 8'h10, 8'h02, 8'h03, 8'h40, 8'h50, 8'hA5};

  // Waits for the start bit on dut_a; returns negedges waited (0 on timeout).
  task automatic wait_start(input int limit, output int cnt);
    cnt = 0;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (tx_a == 1'b0) begin
        cnt = n;
        break;
      end
    end
    if (cnt == 0) chk("start_timeout", 32'd0, 32'd1);
  endtask

  // Called on the first negedge of the start bit; samples mid-bit.
  task automatic recv_frame(input logic [7:0] exp [10], input logic [15:0] exp_cnt);
    logic [9:0] sh;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 10; k++) begin
        if (b == 0 && k == 0) @(negedge clk);
        else repeat (CD) @(negedge clk);
        sh[k] = tx_a;
      end
      chk($sformatf("byte%0d", b), 32'(sh), 32'({1'b1, exp[b], 1'b0}));
    end
    repeat (2) @(negedge clk);
    chk("busy_last", 32'(busy_a), 32'd1);
    @(negedge clk);
    chk("busy_end", 32'(busy_a), 32'd0);
    chk("frame_cnt", 32'(fc_a), 32'(exp_cnt));
  endtask

  int n;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx",   32'(tx_a),   32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_drop", 32'(drop_a), 32'd0);
    chk("rst_cnt",  32'(fc_a),   32'd0);
    a_1i = 16'h1234; a_2i = 16'hABCD; a_1d = 16'h0001; a_2d = 16'hFFFF;
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
    fork
      begin
        // Basic frame and capture latency.
        wait_start(600, n);
        chk("latency1", 32'(n), 32'(DA));
        recv_frame(f1, 16'd1);
        // Inputs scrambled every cycle after capture must not leak into the frame.
        a_1i = 16'h8001; a_2i = 16'h7F10; a_1d = 16'h0203; a_2d = 16'h4050;
        wait_start(600, n);
        fork
          recv_frame(f2, 16'd2);
          repeat (FRAME - 2) begin
            a_1i = 16'($urandom); a_2i = 16'($urandom);
            a_1d = 16'($urandom); a_2d = 16'($urandom);
            @(negedge clk);
          end
        join
        // Async reset at byte 4, bit 3.
        a_1i = 16'h1234; a_2i = 16'h0000; a_1d = 16'h0001; a_2d = 16'hFFFF;
        wait_start(600, n);
        repeat (44 * CD + 1) @(negedge clk);
        chk("b4bit3", 32'(tx_a), 32'd0);
        #2 rst_a = 1'b0;
        #1;
        chk("arst_tx",   32'(tx_a),   32'd1);
        chk("arst_busy", 32'(busy_a), 32'd0);
        chk("arst_cnt",  32'(fc_a),   32'd0);
        a_2i = 16'hABCD;
        @(negedge clk);
        rst_a = 1'b1;
        wait_start(600, n);
        chk("latency_rst", 32'(n), 32'(DA));
        // Enable dropped mid-frame: frame still completes.
        fork
          recv_frame(f1, 16'd1);
          begin
            repeat (100) @(negedge clk);
            en_a = 1'b0;
          end
        join
        for (int c = 0; c < 2000; c++) begin
          @(negedge clk);
          chk("dis_tx", 32'({tx_a, drop_a, fc_a}), 32'({1'b1, 1'b0, 16'd1}));
        end
        en_a = 1'b1;
        wait_start(600, n);
        chk("latency_en", 32'(n), 32'(DA));
        recv_frame(f1, 16'd2);
      end
      begin
        // DECIM=300: tick at 599 hits a busy frame, 899 is accepted.
        repeat (599) @(negedge clk);
        chk("drop599_pre", 32'(drop_b), 32'd0);
        @(negedge clk);
        chk("drop600", 32'(drop_b), 32'd1);
        @(negedge clk);
        chk("drop601", 32'(drop_b), 32'd0);
        repeat (698) @(negedge clk);
        chk("b_cnt1299", 32'(fc_b), 32'd1);
        @(negedge clk);
        chk("b_cnt1300", 32'(fc_b), 32'd2);
      end
    join
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
